// File: rtl/dcache_pkg.sv
// Shared constants and flush FSM state encoding for the data cache line block.
package dcache_pkg;

   localparam int WORD_W     = 32;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      FL_IDLE = 3'd0,
      FL_SCAN = 3'd1,
      FL_READ = 3'd2,
      FL_SEND = 3'd3,
      FL_DONE = 3'd4
   } flush_state_e;

endpackage

// File: rtl/data_cache_word_bank.sv
// One word slot of every cache line: LINES x 32 storage with a byte-enable
// write port, a whole-word fill port and two synchronous read ports (normal
// reads and the flush engine). Storage is deliberately not reset.
module data_cache_word_bank
   import dcache_pkg::*;
#(
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clk_i,
   input  logic                   wr_en_i,
   input  logic [INDEX_WIDTH-1:0] wr_idx_i,
   input  logic [WORD_BYTES-1:0]  wr_be_i,
   input  logic [WORD_W-1:0]      wr_data_i,
   input  logic                   fill_en_i,
   input  logic [INDEX_WIDTH-1:0] fill_idx_i,
   input  logic [WORD_W-1:0]      fill_data_i,
   input  logic [INDEX_WIDTH-1:0] rd_idx_i,
   output logic [WORD_W-1:0]      rd_data_o,
   input  logic                   fr_en_i,
   input  logic [INDEX_WIDTH-1:0] fr_idx_i,
   output logic [WORD_W-1:0]      fr_data_o
);

   localparam int LINES = 2**INDEX_WIDTH;

   logic [WORD_W-1:0] mem_q [LINES];
   logic [WORD_W-1:0] mem_d [LINES];
   logic [WORD_W-1:0] rd_data_q, rd_data_d;
   logic [WORD_W-1:0] fr_data_q, fr_data_d;

   // Next storage contents: fill first, then enabled write bytes win on overlap.
   always_comb begin
      mem_d = mem_q;
      for (int l = 0; l < LINES; l++) begin
         if (fill_en_i && (fill_idx_i == INDEX_WIDTH'(l))) begin
            mem_d[l] = fill_data_i;
         end
      end
      if (wr_en_i) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_be_i[b]) begin
               mem_d[wr_idx_i][b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
         end
      end
   end

   // Read port data; the flush port holds its value unless a capture is requested.
   always_comb begin
      rd_data_d = mem_q[rd_idx_i];
      fr_data_d = fr_en_i ? mem_q[fr_idx_i] : fr_data_q;
   end

   // Data registers, no reset.
   always_ff @(posedge clk_i) begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
      fr_data_q <= fr_data_d;
   end

   assign rd_data_o = rd_data_q;
   assign fr_data_o = fr_data_q;

endmodule

// File: rtl/data_cache_line_block.sv
// Data cache line array with per-line dirty tracking and a flush engine that
// walks the lines and writes back every dirty one over a valid/ready port.
// Optional feature macro DCACHE_WORD_DIRTY_MASK_EN keeps per-word dirty bits
// and reports them on wb_mask_o; without it wb_mask_o is all ones.
module data_cache_line_block
   import dcache_pkg::*;
#(
   parameter int INDEX_WIDTH  = 3,
   parameter int OFFSET_WIDTH = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [INDEX_WIDTH-1:0]                 rd_idx_i,
   output logic [(2**OFFSET_WIDTH)*WORD_W-1:0]    rd_line_o,
   input  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0]    wr_addr_i,
   input  logic [WORD_W-1:0]                      wr_data_i,
   input  logic [WORD_BYTES-1:0]                  wr_be_i,
   input  logic                                   fill_valid_i,
   input  logic [INDEX_WIDTH-1:0]                 fill_idx_i,
   input  logic [(2**OFFSET_WIDTH)*WORD_W-1:0]    fill_line_i,
   input  logic                                   flush_start_i,
   output logic                                   flush_busy_o,
   output logic                                   flush_done_o,
   output logic                                   wb_valid_o,
   input  logic                                   wb_ready_i,
   output logic [INDEX_WIDTH-1:0]                 wb_idx_o,
   output logic [(2**OFFSET_WIDTH)*WORD_W-1:0]    wb_line_o,
   output logic [(2**OFFSET_WIDTH)-1:0]           wb_mask_o,
   output logic [(2**INDEX_WIDTH)-1:0]            dirty_o
);

   localparam int LINES = 2**INDEX_WIDTH;
   localparam int WORDS = 2**OFFSET_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

   logic [INDEX_WIDTH-1:0]  wr_idx;
   logic [OFFSET_WIDTH-1:0] wr_off;
   logic                    wr_en;
   logic                    wr_hits_cnt;
   logic                    handshake;

   flush_state_e            state_q, state_d;
   logic [INDEX_WIDTH-1:0]  cnt_q, cnt_d;
   logic                    hit_q, hit_d;
   logic [LINES-1:0]        dirty_q, dirty_d;

   assign wr_idx      = wr_addr_i[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
   assign wr_off      = wr_addr_i[OFFSET_WIDTH-1:0];
   assign wr_en       = |wr_be_i;
   assign wr_hits_cnt = wr_en && (wr_idx == cnt_q);
   assign handshake   = (state_q == FL_SEND) && wb_ready_i;

   // Flush sequencing; hit_q remembers a write to the line being written back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      case (state_q)
         FL_IDLE: begin
            if (flush_start_i) begin
               state_d = FL_SCAN;
               cnt_d   = '0;
            end
         end
         FL_SCAN: begin
            hit_d = 1'b0;
            if (dirty_q[cnt_q]) begin
               state_d = FL_READ;
            end else if (cnt_q == LAST_IDX) begin
               state_d = FL_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FL_READ: begin
            state_d = FL_SEND;
            if (wr_hits_cnt) hit_d = 1'b1;
         end
         FL_SEND: begin
            if (wr_hits_cnt) hit_d = 1'b1;
            if (wb_ready_i) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = FL_DONE;
               end else begin
                  state_d = FL_SCAN;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         FL_DONE: state_d = FL_IDLE;
         default: state_d = FL_IDLE;
      endcase
   end

   // Line dirty bits: writeback clears, fill clears, a write always sets last.
   always_comb begin
      dirty_d = dirty_q;
      if (handshake && !hit_q) dirty_d[cnt_q] = 1'b0;
      if (fill_valid_i)        dirty_d[fill_idx_i] = 1'b0;
      if (wr_en)               dirty_d[wr_idx] = 1'b1;
   end

`ifdef DCACHE_WORD_DIRTY_MASK_EN
   logic [WORDS-1:0] wmask_q [LINES];
   logic [WORDS-1:0] wmask_d [LINES];
   logic [WORDS-1:0] wb_mask_q, wb_mask_d;

   // Per-word dirty bits follow the line dirty rules; mask is captured with the data.
   always_comb begin
      wmask_d = wmask_q;
      if (handshake && !hit_q) wmask_d[cnt_q] = '0;
      if (fill_valid_i)        wmask_d[fill_idx_i] = '0;
      if (wr_en)               wmask_d[wr_idx][wr_off] = 1'b1;
      wb_mask_d = (state_q == FL_READ) ? wmask_q[cnt_q] : wb_mask_q;
   end

   // Word mask registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int l = 0; l < LINES; l++) wmask_q[l] <= '0;
         wb_mask_q <= '0;
      end else begin
         wmask_q   <= wmask_d;
         wb_mask_q <= wb_mask_d;
      end
   end

   assign wb_mask_o = wb_mask_q;
`else
   assign wb_mask_o = '1;
`endif

   // Control registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FL_IDLE;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         dirty_q <= dirty_d;
      end
   end

   for (genvar w = 0; w < WORDS; w++) begin : g_bank
      data_cache_word_bank #(
         .INDEX_WIDTH (INDEX_WIDTH)
      ) u_bank (
         .clk_i       (clk_i),
         .wr_en_i     (wr_en && (wr_off == OFFSET_WIDTH'(w))),
         .wr_idx_i    (wr_idx),
         .wr_be_i     (wr_be_i),
         .wr_data_i   (wr_data_i),
         .fill_en_i   (fill_valid_i),
         .fill_idx_i  (fill_idx_i),
         .fill_data_i (fill_line_i[w*WORD_W +: WORD_W]),
         .rd_idx_i    (rd_idx_i),
         .rd_data_o   (rd_line_o[w*WORD_W +: WORD_W]),
         .fr_en_i     (state_q == FL_READ),
         .fr_idx_i    (cnt_q),
         .fr_data_o   (wb_line_o[w*WORD_W +: WORD_W])
      );
   end

   assign flush_busy_o = (state_q != FL_IDLE);
   assign flush_done_o = (state_q == FL_DONE);
   assign wb_valid_o   = (state_q == FL_SEND);
   assign wb_idx_o     = cnt_q;
   assign dirty_o      = dirty_q;

endmodule
